cache_miss_ctrl: RTL and testbench

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_miss_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Miss controller between a CPU port, a cache and a single-beat memory port.
// Handles lookup, 4-beat line refill, optional victim write-back, and a single retry.
module cache_miss_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    input  logic [1:0]   cpu_size,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         cpu_err,
    output logic [31:0]  c_addr,
    output logic [31:0]  c_data_in,
    output logic         c_read_enable,
    output logic         c_write_enable,
    output logic         c_load_enable,
    output logic [1:0]   c_byte_size,
    output logic [127:0] c_write_load_data,
    output logic         c_save_ready,
    input  logic         c_data_hit,
    input  logic         c_status_ready,
    input  logic         c_load_complate,
    input  logic         c_save_data,
    input  logic [31:0]  c_data_out,
    input  logic [127:0] c_write_back_data,
    input  logic [31:0]  c_wb_addr,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFetch,
        StLoad,
        StWback,
        StSavedone,
        StRetry,
        StResp
    } state_e;

    // Abort fires on the last permitted wait cycle of a beat.
    localparam logic [31:0] TmoLast = ACK_TIMEOUT - 32'd1;

    state_e         state_q, state_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [1:0]     size_q, size_d;
    logic [1:0]     beat_q, beat_d;
    logic [31:0]    tmo_q, tmo_d;
    logic [127:0]   line_q, line_d;
    logic [127:0]   wb_line_q, wb_line_d;
    logic [31:0]    wb_addr_q, wb_addr_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        beat_d    = beat_q;
        tmo_d     = tmo_q;
        line_d    = line_q;
        wb_line_d = wb_line_q;
        wb_addr_d = wb_addr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    size_d  = cpu_size;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (c_status_ready) begin
                    if (c_data_hit) begin
                        rdata_d = we_q ? 32'd0 : c_data_out;
                        state_d = StResp;
                    end else begin
                        beat_d  = 2'd0;
                        tmo_d   = 32'd0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch, StWback: begin
                if (mem_ack) begin
                    if (state_q == StFetch) begin
                        line_d[{beat_q, 5'b0} +: 32] = mem_rdata;
                    end
                    tmo_d  = 32'd0;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = (state_q == StFetch) ? StLoad : StSavedone;
                    end
                end else if (tmo_q == TmoLast) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StLoad: begin
                // A pending victim takes priority over load completion.
                if (c_save_data) begin
                    wb_line_d = c_write_back_data;
                    wb_addr_d = c_wb_addr;
                    beat_d    = 2'd0;
                    tmo_d     = 32'd0;
                    state_d   = StWback;
                end else if (c_load_complate) begin
                    state_d = StRetry;
                end
            end
            StSavedone: begin
                if (c_load_complate) begin
                    state_d = StRetry;
                end
            end
            StRetry: begin
                if (c_status_ready) begin
                    if (c_data_hit) begin
                        rdata_d = we_q ? 32'd0 : c_data_out;
                    end else begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            size_q    <= 2'd0;
            beat_q    <= 2'd0;
            tmo_q     <= 32'd0;
            line_q    <= 128'd0;
            wb_line_q <= 128'd0;
            wb_addr_q <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
            line_q    <= line_d;
            wb_line_q <= wb_line_d;
            wb_addr_q <= wb_addr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        cpu_rdata         = rdata_q;
        cpu_ready         = (state_q == StResp);
        cpu_err           = (state_q == StResp) && err_q;
        c_addr            = addr_q;
        c_data_in         = wdata_q;
        c_byte_size       = size_q;
        c_write_load_data = line_q;
        c_read_enable     = 1'b0;
        c_write_enable    = 1'b0;
        c_load_enable     = 1'b0;
        c_save_ready      = 1'b0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = 32'd0;
        mem_wdata         = 32'd0;

        if (state_q == StLookup || state_q == StRetry) begin
            c_read_enable  = ~we_q;
            c_write_enable = we_q;
        end
        // Load enable stays up across write-back until the cache finishes the load.
        if (state_q == StLoad || state_q == StWback || state_q == StSavedone) begin
            c_load_enable = 1'b1;
        end
        if (state_q == StSavedone) begin
            c_save_ready = 1'b1;
        end
        if (state_q == StFetch) begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[31:4], beat_q, 2'b00};
        end
        if (state_q == StWback) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {wb_addr_q[31:4], beat_q, 2'b00};
            mem_wdata = wb_line_q[{beat_q, 5'b0} +: 32];
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: cache and memory are driven per step,
// CPU responses are checked against a scoreboard queue.
module tb_cache_miss_ctrl;

    logic         clk;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [1:0]   cpu_size;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_err;
    logic [31:0]  c_addr;
    logic [31:0]  c_data_in;
    logic         c_read_enable;
    logic         c_write_enable;
    logic         c_load_enable;
    logic [1:0]   c_byte_size;
    logic [127:0] c_write_load_data;
    logic         c_save_ready;
    logic         c_data_hit;
    logic         c_status_ready;
    logic         c_load_complate;
    logic         c_save_data;
    logic [31:0]  c_data_out;
    logic [127:0] c_write_back_data;
    logic [31:0]  c_wb_addr;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_cycles = 0;
    logic [32:0] exp_q[$];  // {err, rdata}

    cache_miss_ctrl #(.ACK_TIMEOUT(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_size          (cpu_size),
        .cpu_rdata         (cpu_rdata),
        .cpu_ready         (cpu_ready),
        .cpu_err           (cpu_err),
        .c_addr            (c_addr),
        .c_data_in         (c_data_in),
        .c_read_enable     (c_read_enable),
        .c_write_enable    (c_write_enable),
        .c_load_enable     (c_load_enable),
        .c_byte_size       (c_byte_size),
        .c_write_load_data (c_write_load_data),
        .c_save_ready      (c_save_ready),
        .c_data_hit        (c_data_hit),
        .c_status_ready    (c_status_ready),
        .c_load_complate   (c_load_complate),
        .c_save_data       (c_save_data),
        .c_data_out        (c_data_out),
        .c_write_back_data (c_write_back_data),
        .c_wb_addr         (c_wb_addr),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] all_outputs();
        return 320'({cpu_rdata, cpu_ready, cpu_err, c_addr, c_data_in, c_read_enable,
                     c_write_enable, c_load_enable, c_byte_size, c_write_load_data,
                     c_save_ready, mem_req, mem_we, mem_addr, mem_wdata});
    endfunction

    // Response scoreboard and per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) mem_cycles++;
            check("enable_exclusive",
                  320'($countones({c_read_enable, c_write_enable, c_load_enable}) <= 1),
                  320'(1));
            if (cpu_ready) begin
                check("resp_pending", 320'(exp_q.size() != 0), 320'(1));
                if (exp_q.size() != 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("cpu_rdata", 320'(cpu_rdata), 320'(e[31:0]));
                    check("cpu_err", 320'(cpu_err), 320'(e[32]));
                    check("enables_at_ready",
                          320'({c_read_enable, c_write_enable, c_load_enable, mem_req}),
                          320'(0));
                end
            end else if (cpu_err) begin
                check("err_without_ready", 320'(cpu_err), 320'(0));
            end
        end
    end

    task automatic cpu_issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [32:0] exp);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_size  = 2'b10;
        exp_q.push_back(exp);
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_addr  = ~a;
        cpu_wdata = ~d;
        cpu_size  = 2'b00;
    endtask

    task automatic cache_lookup(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic hit, input logic [31:0] dout);
        int n = 0;
        while (!(c_read_enable || c_write_enable) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("lookup_seen", 320'(n < 50), 320'(1));
        check("lookup_enable", 320'({c_write_enable, c_read_enable}),
              320'(we ? 2'b10 : 2'b01));
        check("lookup_c_addr", 320'(c_addr), 320'(a));
        check("lookup_size", 320'(c_byte_size), 320'(2'b10));
        if (we) check("lookup_c_data_in", 320'(c_data_in), 320'(d));
        c_status_ready = 1'b1;
        c_data_hit     = hit;
        c_data_out     = dout;
        @(negedge clk);
        c_status_ready = 1'b0;
        c_data_hit     = 1'b0;
        c_data_out     = 32'hDEAD_BEEF;
        check("lookup_enable_drop", 320'({c_write_enable, c_read_enable}), 320'(0));
    endtask

    task automatic mem_beats(input logic we, input logic [31:0] base, input logic [127:0] line,
                             input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            int n = 0;
            while (!mem_req && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("beat_seen", 320'(n < 50), 320'(1));
            check("beat_addr", 320'(mem_addr), 320'(base + 32'(4 * k)));
            check("beat_we", 320'(mem_we), 320'(we));
            if (we) check("beat_wdata", 320'(mem_wdata), 320'(line[k*32 +: 32]));
            mem_ack   = 1'b1;
            mem_rdata = we ? 32'd0 : line[k*32 +: 32];
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'd0;
        end
    endtask

    task automatic load_phase(input logic [127:0] exp_line, input logic dirty,
                              input logic [31:0] wb_addr, input logic [127:0] wb_line);
        int n = 0;
        while (!c_load_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("load_seen", 320'(n < 50), 320'(1));
        check("load_line", 320'(c_write_load_data), 320'(exp_line));
        if (dirty) begin
            c_save_data       = 1'b1;
            c_write_back_data = wb_line;
            c_wb_addr         = wb_addr;
            @(negedge clk);
            c_save_data       = 1'b0;
            c_write_back_data = '1;
            c_wb_addr         = '1;
            check("wback_load_en", 320'(c_load_enable), 320'(1));
            mem_beats(1'b1, wb_addr, wb_line, 4);
            for (int i = 0; i < 2; i++) begin
                check("savedone_flags", 320'({c_save_ready, c_load_enable, mem_req}),
                      320'(3'b110));
                @(negedge clk);
            end
        end
        c_load_complate = 1'b1;
        @(negedge clk);
        c_load_complate = 1'b0;
        check("load_drop", 320'({c_save_ready, c_load_enable}), 320'(0));
    endtask

    task automatic wait_resp();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("resp_arrived", 320'(exp_q.size() == 0), 320'(1));
        @(negedge clk);
    endtask

    initial begin
        int m0;
        int n;
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0;
        c_data_hit = 1'b0; c_status_ready = 1'b0; c_load_complate = 1'b0;
        c_save_data = 1'b0; c_data_out = '0; c_write_back_data = '0; c_wb_addr = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 320'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Read hit: no memory traffic.
        m0 = mem_cycles;
        cpu_issue(1'b0, 32'h0000_0004, 32'h0, {1'b0, 32'h1C1C_0000});
        cache_lookup(1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h1C1C_0000);
        wait_resp();
        check("hit_no_mem", 320'(mem_cycles - m0), 320'(0));

        // Clean read miss.
        cpu_issue(1'b0, 32'hA000_0000, 32'h0, {1'b0, 32'h0000_AAAA});
        cache_lookup(1'b0, 32'hA000_0000, 32'h0, 1'b0, 32'h0);
        mem_beats(1'b0, 32'hA000_0000, 128'hAAAA, 4);
        load_phase(128'hAAAA, 1'b0, 32'h0, 128'h0);
        cache_lookup(1'b0, 32'hA000_0000, 32'h0, 1'b1, 32'h0000_AAAA);
        wait_resp();

        // Reset during FETCH beat 2, then a request right after reset release.
        cpu_issue(1'b0, 32'h5000_0024, 32'h0, {1'b0, 32'h0});
        cache_lookup(1'b0, 32'h5000_0024, 32'h0, 1'b0, 32'h0);
        mem_beats(1'b0, 32'h5000_0020, 128'h4_00000003_00000002_00000001, 2);
        check("beat2_pending", 320'({mem_req, mem_addr}), 320'({1'b1, 32'h5000_0028}));
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("reset_mid_fetch", all_outputs(), 320'(0));
        rst_n = 1'b1;
        cpu_issue(1'b0, 32'h0000_0100, 32'h0, {1'b0, 32'h7777_0001});
        check("accept_after_reset", 320'(c_read_enable), 320'(1));
        cache_lookup(1'b0, 32'h0000_0100, 32'h0, 1'b1, 32'h7777_0001);
        wait_resp();

        // Dirty read miss with victim write-back.
        cpu_issue(1'b0, 32'hC000_0000, 32'h0, {1'b0, 32'hC0DE_0001});
        cache_lookup(1'b0, 32'hC000_0000, 32'h0, 1'b0, 32'h0);
        mem_beats(1'b0, 32'hC000_0000, {32'h44, 32'h33, 32'h22, 32'h11}, 4);
        load_phase({32'h44, 32'h33, 32'h22, 32'h11}, 1'b1, 32'h0000_0000,
                   {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'h0000_1234});
        cache_lookup(1'b0, 32'hC000_0000, 32'h0, 1'b1, 32'hC0DE_0001);
        wait_resp();

        // Write miss: write-allocate, completes with rdata 0.
        cpu_issue(1'b1, 32'h0000_0010, 32'h0000_5555, {1'b0, 32'h0});
        cache_lookup(1'b1, 32'h0000_0010, 32'h0000_5555, 1'b0, 32'h0);
        mem_beats(1'b0, 32'h0000_0010, {32'h8, 32'h7, 32'h6, 32'h5}, 4);
        load_phase({32'h8, 32'h7, 32'h6, 32'h5}, 1'b0, 32'h0, 128'h0);
        cache_lookup(1'b1, 32'h0000_0010, 32'h0000_5555, 1'b1, 32'hFFFF_FFFF);
        wait_resp();

        // Miss again on retry: error, no second refill.
        cpu_issue(1'b0, 32'h2000_0008, 32'h0, {1'b1, 32'h0});
        cache_lookup(1'b0, 32'h2000_0008, 32'h0, 1'b0, 32'h0);
        mem_beats(1'b0, 32'h2000_0000, 128'h1, 4);
        load_phase(128'h1, 1'b0, 32'h0, 128'h0);
        m0 = mem_cycles;
        cache_lookup(1'b0, 32'h2000_0008, 32'h0, 1'b0, 32'h0);
        wait_resp();
        check("retry_miss_no_refill", 320'(mem_cycles - m0), 320'(0));

        // Ack timeout: mem_req held exactly ACK_TIMEOUT cycles, then error.
        cpu_issue(1'b0, 32'h3000_0040, 32'h0, {1'b1, 32'h0});
        cache_lookup(1'b0, 32'h3000_0040, 32'h0, 1'b0, 32'h0);
        n = 0;
        while (mem_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", 320'(n), 320'(8));
        wait_resp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
